steer_en: RTL and testbench



---
 rtl/steer_en.sv | 138 +++++++++++++
 tb/tb_steer_en.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/steer_en.sv
// Rider-detect and steering-enable stage: decides rider presence and steering permission
// from the two load-cell readings, and registers the saturated left-right difference.
module steer_en #(
   parameter bit          fast_sim      = 1'b0,
   parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
   parameter logic [11:0] WT_HYSTERESIS = 12'h40
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   output logic        en_steer,
   output logic        rider_off,
   output logic [11:0] ld_cell_diff
);

   localparam int unsigned LD_W   = 12;
   localparam int unsigned SUM_W  = 13;
   localparam int unsigned TMR_W  = 26;
   localparam int unsigned FAST_W = 15;

   localparam logic [SUM_W-1:0] THR_HI = SUM_W'(MIN_RIDER_WT) + SUM_W'(WT_HYSTERESIS);
   localparam logic [SUM_W-1:0] THR_LO = SUM_W'(MIN_RIDER_WT) - SUM_W'(WT_HYSTERESIS);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      STEER = 2'b10
   } state_t;

   state_t            state;
   state_t            nxt;
   logic [TMR_W-1:0]  tmr;
   logic [TMR_W-1:0]  tmr_nxt;
   logic [SUM_W-1:0]  sum;
   logic [SUM_W-1:0]  diff;
   logic [SUM_W-1:0]  neg_diff;
   logic [LD_W-1:0]   abs_diff;
   logic [SUM_W-1:0]  abs_ext;
   logic [LD_W-1:0]   sat_diff;
   logic              sum_gt_min;
   logic              sum_lt_min;
   logic              diff_gt_1_4;
   logic              diff_gt_15_16;
   logic              tmr_full;

   // Load-cell arithmetic, all 13-bit unsigned compares
   always_comb begin
      sum           = SUM_W'(lft_ld) + SUM_W'(rght_ld);
      diff          = SUM_W'(lft_ld) - SUM_W'(rght_ld);
      neg_diff      = SUM_W'(0) - diff;
      abs_diff      = diff[SUM_W-1] ? neg_diff[LD_W-1:0] : diff[LD_W-1:0];
      abs_ext       = SUM_W'(abs_diff);
      sum_gt_min    = (sum > THR_HI);
      sum_lt_min    = (sum < THR_LO);
      diff_gt_1_4   = (abs_ext > (sum >> 2));
      diff_gt_15_16 = (abs_ext > (sum - (sum >> 4)));
   end

   // diff spans -4095..4095; bits 12:11 disagreeing means it left the 12-bit signed range
   always_comb begin
      sat_diff = diff[LD_W-1:0];
      if (!diff[SUM_W-1] && diff[LD_W-1])
         sat_diff = 12'h7FF;
      else if (diff[SUM_W-1] && !diff[LD_W-1])
         sat_diff = 12'h800;
   end

   always_comb begin
      if (fast_sim)
         tmr_full = &tmr[FAST_W-1:0];
      else
         tmr_full = &tmr;
   end

   // Stability timer only runs while waiting on an evenly-loaded rider
   always_comb begin
      tmr_nxt = '0;
      if (state == WAIT && !diff_gt_1_4)
         tmr_nxt = tmr + TMR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   // Next state; the low-weight exit always takes priority over diff conditions
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE: begin
            if (sum_gt_min)
               nxt = WAIT;
            else
               nxt = IDLE;
         end
         WAIT: begin
            if (sum_lt_min)
               nxt = IDLE;
            else if (diff_gt_1_4)
               nxt = WAIT;
            else if (tmr_full)
               nxt = STEER;
            else
               nxt = WAIT;
         end
         STEER: begin
            if (sum_lt_min)
               nxt = IDLE;
            else if (diff_gt_15_16)
               nxt = WAIT;
            else
               nxt = STEER;
         end
         default: nxt = IDLE;
      endcase
   end

   // Outputs are flops loaded with the decoded next state, so they track the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr          <= '0;
         ld_cell_diff <= '0;
         rider_off    <= 1'b1;
         en_steer     <= 1'b0;
      end else begin
         tmr          <= tmr_nxt;
         ld_cell_diff <= sat_diff;
         rider_off    <= (nxt == IDLE);
         en_steer     <= (nxt == STEER);
      end
   end

endmodule

// File: tb/tb_steer_en.sv
// Directed bench for steer_en with the shortened stability timer (2^15 cycles).
module tb_steer_en;

   logic        clk;
   logic        rst_n;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic        en_steer;
   logic        rider_off;
   logic [11:0] ld_cell_diff;

   int total;
   int bad;

   localparam int unsigned WAIT_CYC = 32768;

   steer_en #(.fast_sim(1'b1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .lft_ld       (lft_ld),
      .rght_ld      (rght_ld),
      .en_steer     (en_steer),
      .rider_off    (rider_off),
      .ld_cell_diff (ld_cell_diff)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [11:0] l, input logic [11:0] r);
      lft_ld  = l;
      rght_ld = r;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      drive(12'd300, 12'd300);

      // Reset holds outputs even across clock edges
      tick(2);
      check("rst_rider_off", 32'(rider_off), 32'd1);
      check("rst_en_steer", 32'(en_steer), 32'd0);
      check("rst_diff", 32'(ld_cell_diff), 32'd0);

      rst_n = 1'b1;
      tick(1);
      check("wait_entry_rider_off", 32'(rider_off), 32'd0);
      check("wait_entry_en", 32'(en_steer), 32'd0);
      tick(WAIT_CYC - 1);
      check("steer_early", 32'(en_steer), 32'd0);
      tick(1);
      check("steer_exact", 32'(en_steer), 32'd1);

      // STEER holds with moderate imbalance and inside the hysteresis band
      drive(12'd500, 12'd100);
      tick(1);
      check("steer_hold_400", 32'(en_steer), 32'd1);
      check("diff_400", 32'(ld_cell_diff), 32'd400);
      drive(12'd250, 12'd250);
      tick(1);
      check("steer_hold_500", 32'(en_steer), 32'd1);
      check("steer_hold_500_ro", 32'(rider_off), 32'd0);
      drive(12'd224, 12'd224);
      tick(1);
      check("steer_hold_448", 32'(en_steer), 32'd1);

      // Async reset between edges, effective before any clock
      drive(12'd300, 12'd300);
      rst_n = 1'b0;
      #2;
      check("async_en", 32'(en_steer), 32'd0);
      check("async_ro", 32'(rider_off), 32'd1);
      check("async_diff", 32'(ld_cell_diff), 32'd0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      check("rewait_ro", 32'(rider_off), 32'd0);
      tick(11999);
      check("rewait_mid_en", 32'(en_steer), 32'd0);

      // A one-cycle imbalance restarts the stability timer
      drive(12'd400, 12'd200);
      tick(1);
      check("glitch_en", 32'(en_steer), 32'd0);
      check("glitch_ro", 32'(rider_off), 32'd0);
      check("glitch_diff", 32'(ld_cell_diff), 32'd200);
      drive(12'd300, 12'd300);
      tick(WAIT_CYC - 1);
      check("restart_early", 32'(en_steer), 32'd0);
      tick(1);
      check("restart_exact", 32'(en_steer), 32'd1);

      // Extreme imbalance drops back to WAIT, rider still on
      drive(12'd500, 12'd100);
      tick(1);
      check("steer_hold2", 32'(en_steer), 32'd1);
      drive(12'd590, 12'd10);
      tick(1);
      check("drop_en", 32'(en_steer), 32'd0);
      check("drop_ro", 32'(rider_off), 32'd0);
      check("drop_diff", 32'(ld_cell_diff), 32'd580);
      drive(12'd224, 12'd224);
      tick(1);
      check("wait_hold_448", 32'(rider_off), 32'd0);
      drive(12'd220, 12'd220);
      tick(1);
      check("leave_440_ro", 32'(rider_off), 32'd1);
      check("leave_440_en", 32'(en_steer), 32'd0);

      // IDLE hysteresis: 500 and exactly 576 stay, 577 leaves
      drive(12'd250, 12'd250);
      tick(1);
      check("idle_500", 32'(rider_off), 32'd1);
      drive(12'd288, 12'd288);
      tick(1);
      check("idle_576", 32'(rider_off), 32'd1);
      drive(12'd289, 12'd288);
      tick(1);
      check("idle_577", 32'(rider_off), 32'd0);

      // Saturated difference, one clock latency
      drive(12'd4095, 12'd0);
      tick(1);
      check("sat_pos", 32'(ld_cell_diff), 32'h7FF);
      drive(12'd0, 12'd4095);
      tick(1);
      check("sat_neg", 32'(ld_cell_diff), 32'h800);
      drive(12'd1000, 12'd1200);
      tick(1);
      check("diff_m200", 32'(ld_cell_diff), 32'hF38);
      drive(12'd1200, 12'd1000);
      tick(1);
      check("diff_p200", 32'(ld_cell_diff), 32'h0C8);
      drive(12'd2047, 12'd0);
      tick(1);
      check("diff_2047", 32'(ld_cell_diff), 32'h7FF);
      drive(12'd2048, 12'd0);
      tick(1);
      check("diff_2048", 32'(ld_cell_diff), 32'h7FF);
      drive(12'd0, 12'd2048);
      tick(1);
      check("diff_m2048", 32'(ld_cell_diff), 32'h800);
      drive(12'd0, 12'd2049);
      tick(1);
      check("diff_m2049", 32'(ld_cell_diff), 32'h800);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
